// File: rtl/rfphoenix_pma_checker_if.sv
// rfphoenix_pma_checker_if: request/response handshake bundle of the PMA checker.
// master = address generation + response consumer, slave = checker stage.
interface rfphoenix_pma_checker_if #(
   parameter int AWID = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [AWID-1:0] req_adr;
   logic [1:0]      req_cmd;
   logic [1:0]      req_size;
   logic [3:0]      req_tag;

   logic            resp_valid;
   logic            resp_ready;
   logic [AWID-1:0] resp_adr;
   logic [3:0]      resp_tag;
   logic [3:0]      resp_region;
   logic            resp_cacheable;
   logic            resp_fault;
   logic [2:0]      resp_cause;

   modport master (
      output req_valid,
      output req_adr,
      output req_cmd,
      output req_size,
      output req_tag,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_adr,
      input  resp_tag,
      input  resp_region,
      input  resp_cacheable,
      input  resp_fault,
      input  resp_cause
   );

   modport slave (
      input  req_valid,
      input  req_adr,
      input  req_cmd,
      input  req_size,
      input  req_tag,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_adr,
      output resp_tag,
      output resp_region,
      output resp_cacheable,
      output resp_fault,
      output resp_cause
   );
endinterface

// File: rtl/rfphoenix_pma_checker.sv
// rfphoenix_pma_checker: PMA permission/alignment check stage with fault capture.
// Optional PMA_CHECK_LOCK_EN: first fault locks the captured address/cause.
module rfphoenix_pma_checker #(
   parameter int AWID  = 32,
   parameter int FCNTW = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   rfphoenix_pma_checker_if.slave bus,
   output logic [AWID-1:0]  rgn_adr,
   input  logic [19:0]      rgn_at,
   input  logic [3:0]       rgn_num,
   input  logic             rgn_err,
   output logic [AWID-1:0]  fault_adr,
   output logic [2:0]       fault_cause,
   output logic [FCNTW-1:0] fault_cnt,
   input  logic             fault_clr
);

   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_RGN  = 3'd1;
   localparam logic [2:0] C_NACC = 3'd2;
   localparam logic [2:0] C_RD   = 3'd3;
   localparam logic [2:0] C_WR   = 3'd4;
   localparam logic [2:0] C_EX   = 3'd5;
   localparam logic [2:0] C_MIS  = 3'd6;

   logic            at_x;
   logic            at_w;
   logic            at_r;
   logic            at_c;
   logic            no_acc;
   logic            is_rd;
   logic            is_wr;
   logic            is_ex;
   logic            misal;
   logic [2:0]      cause;
   logic            flt;
   logic            acc;
   logic            cap;
   logic            upd;

   logic            rv_q;
   logic [AWID-1:0] radr_q;
   logic [3:0]      rtag_q;
   logic [3:0]      rrgn_q;
   logic            rc_q;
   logic            rf_q;
   logic [2:0]      rcause_q;

   logic [AWID-1:0]  fadr_q;
   logic [2:0]       fcause_q;
   logic [FCNTW-1:0] fcnt_q;

   assign rgn_adr = bus.req_adr;

   assign at_x   = rgn_at[0];
   assign at_w   = rgn_at[1];
   assign at_r   = rgn_at[2];
   assign at_c   = rgn_at[3];
   assign no_acc = (rgn_at[15:8] == 8'hFF);

   // cmd 3 is reserved and checked as a read
   assign is_rd = (bus.req_cmd == 2'd0) || (bus.req_cmd == 2'd3);
   assign is_wr = (bus.req_cmd == 2'd1);
   assign is_ex = (bus.req_cmd == 2'd2);

   always_comb begin
      misal = 1'b0;
      unique case (bus.req_size)
         2'd0: misal = 1'b0;
         2'd1: misal = bus.req_adr[0];
         2'd2: misal = |bus.req_adr[1:0];
         2'd3: misal = |bus.req_adr[2:0];
      endcase
   end

   always_comb begin
      cause = C_NONE;
      if (rgn_err)
         cause = C_RGN;
      else if (no_acc)
         cause = C_NACC;
      else if (is_rd && !at_r)
         cause = C_RD;
      else if (is_wr && !at_w)
         cause = C_WR;
      else if (is_ex && !at_x)
         cause = C_EX;
      else if (misal)
         cause = C_MIS;
   end

   assign flt = (cause != C_NONE);

   assign bus.req_ready = !rv_q || bus.resp_ready;
   assign acc = bus.req_valid && bus.req_ready;
   assign cap = acc && flt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv_q     <= 1'b0;
         radr_q   <= '0;
         rtag_q   <= '0;
         rrgn_q   <= '0;
         rc_q     <= 1'b0;
         rf_q     <= 1'b0;
         rcause_q <= C_NONE;
      end else if (acc) begin
         rv_q     <= 1'b1;
         radr_q   <= bus.req_adr;
         rtag_q   <= bus.req_tag;
         rrgn_q   <= rgn_num;
         rc_q     <= at_c && !flt;
         rf_q     <= flt;
         rcause_q <= cause;
      end else if (bus.resp_ready) begin
         rv_q     <= 1'b0;
      end
   end

   assign bus.resp_valid     = rv_q;
   assign bus.resp_adr       = radr_q;
   assign bus.resp_tag       = rtag_q;
   assign bus.resp_region    = rrgn_q;
   assign bus.resp_cacheable = rc_q;
   assign bus.resp_fault     = rf_q;
   assign bus.resp_cause     = rcause_q;

`ifdef PMA_CHECK_LOCK_EN
   logic lock_q;

   // a clear in the capture cycle reopens the record for this fault
   assign upd = !lock_q || fault_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lock_q <= 1'b0;
      else if (cap)
         lock_q <= 1'b1;
      else if (fault_clr)
         lock_q <= 1'b0;
   end
`else
   assign upd = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fadr_q   <= '0;
         fcause_q <= C_NONE;
         fcnt_q   <= '0;
      end else if (cap) begin
         if (upd) begin
            fadr_q   <= bus.req_adr;
            fcause_q <= cause;
         end
         if (fault_clr)
            fcnt_q <= FCNTW'(1);
         else if (!(&fcnt_q))
            fcnt_q <= fcnt_q + FCNTW'(1);
      end else if (fault_clr) begin
         fadr_q   <= '0;
         fcause_q <= C_NONE;
         fcnt_q   <= '0;
      end
   end

   assign fault_adr   = fadr_q;
   assign fault_cause = fcause_q;
   assign fault_cnt   = fcnt_q;

endmodule

// File: tb/tb_rfphoenix_pma_checker.sv
// tb_rfphoenix_pma_checker: scoreboard bench for the PMA checker stage.
// Responses are checked against a queue filled at accept time.
module tb_rfphoenix_pma_checker;

   logic        clk;
   logic        rst_n;
   logic [31:0] rgn_adr;
   logic [19:0] rgn_at;
   logic [3:0]  rgn_num;
   logic        rgn_err;
   logic [31:0] fault_adr;
   logic [2:0]  fault_cause;
   logic [7:0]  fault_cnt;
   logic        fault_clr;

   rfphoenix_pma_checker_if #(.AWID(32)) bus ();

   rfphoenix_pma_checker #(.AWID(32), .FCNTW(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .rgn_adr     (rgn_adr),
      .rgn_at      (rgn_at),
      .rgn_num     (rgn_num),
      .rgn_err     (rgn_err),
      .fault_adr   (fault_adr),
      .fault_cause (fault_cause),
      .fault_cnt   (fault_cnt),
      .fault_clr   (fault_clr)
   );

   typedef struct {
      logic [31:0] adr;
      logic [3:0]  tag;
      logic [3:0]  rgn;
      logic        c;
      logic        f;
      logic [2:0]  cause;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_adr;
   logic [2:0]  m_cause;
   logic [7:0]  m_cnt;
   logic        m_lock;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] model_cause(
      input logic [31:0] adr, input logic [1:0] cmd,
      input logic [1:0] size, input logic [19:0] at,
      input logic err);
      int unsigned bytes;
      bytes = 1 << size;
      if (err) return 3'd1;
      if (at[15:8] == 8'hFF) return 3'd2;
      if ((cmd == 2'd0 || cmd == 2'd3) && !at[2]) return 3'd3;
      if (cmd == 2'd1 && !at[1]) return 3'd4;
      if (cmd == 2'd2 && !at[0]) return 3'd5;
      if ((adr % bytes) != 0) return 3'd6;
      return 3'd0;
   endfunction

   task automatic model_clear();
      m_adr   = '0;
      m_cause = '0;
      m_cnt   = '0;
      m_lock  = 1'b0;
   endtask

   task automatic set_req(input logic [31:0] adr, input logic [1:0] cmd,
                          input logic [1:0] size, input logic [3:0] tag,
                          input logic [19:0] at, input logic [3:0] num,
                          input logic err);
      bus.req_valid = 1'b1;
      bus.req_adr   = adr;
      bus.req_cmd   = cmd;
      bus.req_size  = size;
      bus.req_tag   = tag;
      rgn_at        = at;
      rgn_num       = num;
      rgn_err       = err;
   endtask

   task automatic tick();
      exp_t       e;
      logic [2:0] c;
      logic       acc;
      #1;
      if (bus.resp_valid && bus.resp_ready) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got adr=%h with empty queue", bus.resp_adr);
         end else begin
            e = q.pop_front();
            if ({bus.resp_adr, bus.resp_tag, bus.resp_region, bus.resp_cacheable,
                 bus.resp_fault, bus.resp_cause} !==
                {e.adr, e.tag, e.rgn, e.c, e.f, e.cause}) begin
               bad++;
               $display("FAIL sb_resp: got adr=%h tag=%h rgn=%h c=%b f=%b cause=%0d want adr=%h tag=%h rgn=%h c=%b f=%b cause=%0d",
                        bus.resp_adr, bus.resp_tag, bus.resp_region,
                        bus.resp_cacheable, bus.resp_fault, bus.resp_cause,
                        e.adr, e.tag, e.rgn, e.c, e.f, e.cause);
            end
         end
      end
      acc = bus.req_valid && bus.req_ready;
      c = model_cause(bus.req_adr, bus.req_cmd, bus.req_size, rgn_at, rgn_err);
      if (acc) begin
         e.adr   = bus.req_adr;
         e.tag   = bus.req_tag;
         e.rgn   = rgn_num;
         e.c     = (c == 3'd0) ? rgn_at[3] : 1'b0;
         e.f     = (c != 3'd0);
         e.cause = c;
         q.push_back(e);
      end
      if (acc && c != 3'd0) begin
`ifdef PMA_CHECK_LOCK_EN
         if (!m_lock || fault_clr) begin
            m_adr   = bus.req_adr;
            m_cause = c;
         end
         m_lock = 1'b1;
`else
         m_adr   = bus.req_adr;
         m_cause = c;
`endif
         if (fault_clr) m_cnt = 8'd1;
         else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else if (fault_clr) begin
         model_clear();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      bus.resp_ready = 1'b1;
      idle();
      for (int i = 0; i < 10 && (q.size() != 0 || bus.resp_valid); i++) tick();
      total++;
      if (q.size() != 0 || bus.resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_timeout: left=%0d resp_valid=%b want 0 0",
                  q.size(), bus.resp_valid);
      end
   endtask

   task automatic chk_rec(input string nm, input logic [31:0] a,
                          input logic [2:0] c, input logic [7:0] n);
      total++;
      if ({fault_adr, fault_cause, fault_cnt} !== {a, c, n}) begin
         bad++;
         $display("FAIL %s: got adr=%h cause=%0d cnt=%0d want adr=%h cause=%0d cnt=%0d",
                  nm, fault_adr, fault_cause, fault_cnt, a, c, n);
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({bus.resp_valid, bus.resp_adr, bus.resp_tag, bus.resp_region,
           bus.resp_cacheable, bus.resp_fault, bus.resp_cause} !== '0 ||
          bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_resp: valid=%b adr=%h ready=%b want 0 0 1",
                  bus.resp_valid, bus.resp_adr, bus.req_ready);
      end
      chk_rec("reset_rec", 32'h0, 3'd0, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bus.resp_ready = 1'b1;
      set_req(32'h0000_1000, 2'd0, 2'd2, 4'h3, 20'h0010F, 4'd1, 1'b0);
      #1;
      total++;
      if (rgn_adr !== 32'h0000_1000) begin
         bad++;
         $display("FAIL rgn_adr: got %h want 00001000", rgn_adr);
      end
      tick();
      idle();
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_fault !== 1'b0 ||
          bus.resp_cacheable !== 1'b1 || bus.resp_region !== 4'd1) begin
         bad++;
         $display("FAIL basic_read: v=%b f=%b c=%b rgn=%0d want 1 0 1 1",
                  bus.resp_valid, bus.resp_fault, bus.resp_cacheable, bus.resp_region);
      end
      chk_rec("basic_rec", 32'h0, 3'd0, 8'd0);
      drain();
   endtask

   task automatic test_write_fault();
      set_req(32'hFFFD_0010, 2'd1, 2'd2, 4'h5, 20'h0000D, 4'd2, 1'b0);
      tick();
      idle();
      total++;
      if (bus.resp_cause !== 3'd4 || bus.resp_cacheable !== 1'b0) begin
         bad++;
         $display("FAIL write_fault: cause=%0d c=%b want 4 0",
                  bus.resp_cause, bus.resp_cacheable);
      end
      chk_rec("write_rec", 32'hFFFD_0010, 3'd4, 8'd1);
      drain();
   endtask

   task automatic test_exec_prio();
      set_req(32'hFF80_0000, 2'd2, 2'd2, 4'h6, 20'h00206, 4'd3, 1'b0);
      tick();
      total++;
      if (bus.resp_cause !== 3'd5) begin
         bad++;
         $display("FAIL exec_nox: cause=%0d want 5", bus.resp_cause);
      end
      set_req(32'hFF80_0000, 2'd2, 2'd2, 4'h7, 20'h00206, 4'd3, 1'b1);
      tick();
      idle();
      total++;
      if (bus.resp_cause !== 3'd1) begin
         bad++;
         $display("FAIL exec_rgnerr: cause=%0d want 1", bus.resp_cause);
      end
      drain();
   endtask

   task automatic test_align();
      set_req(32'h0000_0006, 2'd0, 2'd2, 4'h8, 20'h0010F, 4'd1, 1'b0);
      tick();
      total++;
      if (bus.resp_cause !== 3'd6) begin
         bad++;
         $display("FAIL misalign: cause=%0d want 6", bus.resp_cause);
      end
      set_req(32'h0000_0004, 2'd0, 2'd2, 4'h9, 20'h0010F, 4'd1, 1'b0);
      tick();
      total++;
      if (bus.resp_fault !== 1'b0) begin
         bad++;
         $display("FAIL aligned: fault=%b want 0", bus.resp_fault);
      end
      set_req(32'h0000_0004, 2'd1, 2'd3, 4'hA, 20'h0010F, 4'd1, 1'b0);
      tick();
      set_req(32'h0000_0008, 2'd3, 2'd3, 4'hB, 20'h0010F, 4'd1, 1'b0);
      tick();
      set_req(32'h0000_0003, 2'd1, 2'd0, 4'hC, 20'h0FF0F, 4'd1, 1'b0);
      tick();
      set_req(32'h0000_0001, 2'd0, 2'd1, 4'hD, 20'h0000F, 4'd1, 1'b0);
      tick();
      idle();
      drain();
   endtask

   task automatic test_back_to_back();
      bus.resp_ready = 1'b0;
      set_req(32'h0000_2000, 2'd0, 2'd2, 4'h1, 20'h0010F, 4'd4, 1'b0);
      tick();
      set_req(32'h0000_2010, 2'd1, 2'd2, 4'h2, 20'h00002, 4'd5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 ||
             bus.resp_adr !== 32'h0000_2000 || bus.resp_tag !== 4'h1) begin
            bad++;
            $display("FAIL stall_%0d: rdy=%b v=%b adr=%h tag=%h want 0 1 00002000 1",
                     i, bus.req_ready, bus.resp_valid, bus.resp_adr, bus.resp_tag);
         end
      end
      bus.resp_ready = 1'b1;
      #1;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL release_ready: got %b want 1", bus.req_ready);
      end
      tick();
      set_req(32'h0000_2020, 2'd2, 2'd2, 4'h3, 20'h00001, 4'd6, 1'b0);
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_adr !== 32'h0000_2010) begin
         bad++;
         $display("FAIL no_bubble: v=%b adr=%h want 1 00002010",
                  bus.resp_valid, bus.resp_adr);
      end
      tick();
      idle();
      drain();
   endtask

   task automatic test_saturate();
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         set_req(32'h0001_0000 + 32'(i * 4), 2'd0, 2'd2, 4'(i), 20'h00000, 4'd7, 1'b0);
         tick();
      end
      idle();
      drain();
      chk_rec("saturate", 32'h0001_0000 + 32'(299 * 4), 3'd3, 8'hFF);
      fault_clr = 1'b1;
      set_req(32'h0000_3000, 2'd0, 2'd2, 4'h4, 20'h0FF07, 4'd8, 1'b0);
      tick();
      fault_clr = 1'b0;
      idle();
      chk_rec("clr_and_fault", 32'h0000_3000, 3'd2, 8'd1);
      drain();
   endtask

   task automatic test_lock();
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk_rec("clr_only", 32'h0, 3'd0, 8'd0);
      set_req(32'h0000_4000, 2'd0, 2'd2, 4'h1, 20'h0000B, 4'd9, 1'b0);
      tick();
      set_req(32'h0000_4004, 2'd1, 2'd2, 4'h2, 20'h00005, 4'd9, 1'b0);
      tick();
      idle();
`ifdef PMA_CHECK_LOCK_EN
      chk_rec("lock_two", 32'h0000_4000, 3'd3, 8'd2);
`else
      chk_rec("newest_two", 32'h0000_4004, 3'd4, 8'd2);
`endif
      chk_rec("model_rec", m_adr, m_cause, m_cnt);
      drain();
   endtask

   task automatic test_reset_drop();
      bus.resp_ready = 1'b0;
      set_req(32'h0000_5002, 2'd0, 2'd2, 4'hE, 20'h0010F, 4'd1, 1'b0);
      tick();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || fault_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_drop: v=%b rdy=%b cnt=%0d want 0 1 0",
                  bus.resp_valid, bus.req_ready, fault_cnt);
      end
      q.delete();
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drain();
   endtask

   initial begin
      rst_n          = 1'b0;
      fault_clr      = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_adr    = '0;
      bus.req_cmd    = '0;
      bus.req_size   = '0;
      bus.req_tag    = '0;
      bus.resp_ready = 1'b0;
      rgn_at         = '0;
      rgn_num        = '0;
      rgn_err        = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_write_fault();
      test_exec_prio();
      test_align();
      test_back_to_back();
      test_saturate();
      test_lock();
      test_reset_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
